// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA barrel shifter with valid/ready handshakes on both sides.
// Define SHIFT_WORD_OPS_EN to add the in_word port for RV64 SLLW/SRLW/SRAW (XLEN=64 only).
module shift_unit_pipe #(
    parameter int XLEN        = 64,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_a,
    input  logic [$clog2(XLEN)-1:0]  in_n,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
`ifdef SHIFT_WORD_OPS_EN
    input  logic                     in_word,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    localparam int LOG_W = $clog2(XLEN);
    typedef logic [LOG_W-1:0] amt_t;

    // Amount bit b belongs to stage floor(b*PIPE_STAGES/LOG_W).
    function automatic amt_t stage_mask(input int k);
        amt_t m;
        m = '0;
        for (int b = 0; b < LOG_W; b++)
            if ((b * PIPE_STAGES) / LOG_W == k) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] d, input amt_t amt,
                                                   input logic [1:0] op, input logic sgn);
        logic [XLEN:0] ext;
        logic [XLEN-1:0] r;
        ext = '0;
        r   = d;
        case (op)
            2'b00: r = d << amt;
            2'b01: r = d >> amt;
            2'b11: begin
                ext = $signed({sgn, d}) >>> amt;
                r   = ext[XLEN-1:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] adv;
    logic [PIPE_STAGES-1:0] load;
    logic [XLEN-1:0]        d_q   [PIPE_STAGES];
    amt_t                   n_q   [PIPE_STAGES];
    logic [1:0]             op_q  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
    logic                   s_q   [PIPE_STAGES];

    logic [XLEN-1:0]        src_d   [PIPE_STAGES];
    amt_t                   src_n   [PIPE_STAGES];
    logic [1:0]             src_op  [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag [PIPE_STAGES];
    logic                   src_s   [PIPE_STAGES];
    logic [XLEN-1:0]        shd     [PIPE_STAGES];

    logic [XLEN-1:0] a_pre;
    amt_t            n_pre;
    logic            s_pre;

`ifdef SHIFT_WORD_OPS_EN
    logic w_q   [PIPE_STAGES];
    logic src_w [PIPE_STAGES];
`endif

    // Word ops run on a full-width datapath: the low half is zero/sign-extended up front
    // so right shifts pull in the correct fill, and the result is sign-extended at the end.
    always_comb begin
        a_pre = in_a;
        n_pre = in_n;
        s_pre = in_a[XLEN-1];
`ifdef SHIFT_WORD_OPS_EN
        if (in_word && in_op != 2'b10) begin
            n_pre[LOG_W-1] = 1'b0;
            s_pre          = in_a[31];
            a_pre          = {{(XLEN-32){(in_op == 2'b11) & in_a[31]}}, in_a[31:0]};
        end
`endif
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_d[k]   = a_pre;
            assign src_n[k]   = n_pre;
            assign src_op[k]  = in_op;
            assign src_tag[k] = in_tag;
            assign src_s[k]   = s_pre;
`ifdef SHIFT_WORD_OPS_EN
            assign src_w[k]   = in_word;
`endif
        end else begin : g_body
            assign src_d[k]   = d_q[k-1];
            assign src_n[k]   = n_q[k-1];
            assign src_op[k]  = op_q[k-1];
            assign src_tag[k] = tag_q[k-1];
            assign src_s[k]   = s_q[k-1];
`ifdef SHIFT_WORD_OPS_EN
            assign src_w[k]   = w_q[k-1];
`endif
        end
        assign shd[k] = shift_step(src_d[k], src_n[k] & stage_mask(k), src_op[k], src_s[k]);
    end

    // Advance chain runs from the output back toward the input.
    always_comb begin
        adv = '0;
        adv[PIPE_STAGES-1] = v_q[PIPE_STAGES-1] & out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--)
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int k = 1; k < PIPE_STAGES; k++)
            load[k] = adv[k-1];
    end

    assign in_ready = ~v_q[0] | adv[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                d_q[k]   <= '0;
                n_q[k]   <= '0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
                s_q[k]   <= 1'b0;
`ifdef SHIFT_WORD_OPS_EN
                w_q[k]   <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                v_q[k] <= load[k] | (v_q[k] & ~adv[k]);
                if (load[k]) begin
                    d_q[k]   <= shd[k];
                    n_q[k]   <= src_n[k];
                    op_q[k]  <= src_op[k];
                    tag_q[k] <= src_tag[k];
                    s_q[k]   <= src_s[k];
`ifdef SHIFT_WORD_OPS_EN
                    w_q[k]   <= src_w[k];
`endif
                end
            end
        end
    end

    always_comb begin
        out_result = d_q[PIPE_STAGES-1];
`ifdef SHIFT_WORD_OPS_EN
        if (w_q[PIPE_STAGES-1] && op_q[PIPE_STAGES-1] != 2'b10)
            out_result = {{(XLEN-32){d_q[PIPE_STAGES-1][31]}}, d_q[PIPE_STAGES-1][31:0]};
`endif
    end

    assign out_valid = v_q[PIPE_STAGES-1];
    assign out_tag   = tag_q[PIPE_STAGES-1];
    assign busy      = |v_q;

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter for the execute stage. It supersedes the single-cycle combinational 64-bit left shifter.
- Supports SLL, SRL and SRA at any power-of-two XLEN.
- Spreads the log2(XLEN) mux levels over PIPE_STAGES register stages.
- Carries a destination tag alongside each operation.
- Uses valid/ready handshakes on both sides, so the pipeline can stall without losing operations.

Parameters:
XLEN, 64, data width; must be a power of two, at least 8.
PIPE_STAGES, 2, number of register stages (1..log2(XLEN)); also the latency.
TAG_W, 5, width of the sideband tag (rd index).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  an operation is presented.
in_ready  output  1  the unit accepts on this cycle if in_valid is high.
in_a  input  XLEN  operand.
in_n  input  log2(XLEN)  shift amount.
in_op  input  2  operation select: 00 SLL, 01 SRL, 11 SRA, 10 reserved (result = in_a unchanged).
in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_result  output  XLEN  shifted value.
out_tag  output  TAG_W  tag of out_result.
busy  output  1  OR of all stage valid bits.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear; out_valid=0, out_result=0, out_tag=0, busy=0.
  - in_ready=1 once the first stage is empty.
  - Operations in flight at reset are discarded; nothing is emitted after reset releases.
- Acceptance: an operation is accepted when in_valid & in_ready at a rising edge.
- Stage structure:
  - Stages 0..PIPE_STAGES-1 each hold a valid bit, the partial result, the remaining shift bits, op, tag and a sign bit.
  - Bit b of in_n is applied in stage floor(b*PIPE_STAGES/log2(XLEN)).
  - Example, XLEN=64, PIPE_STAGES=2: stage 0 applies n[2:0], stage 1 applies n[5:3].
- Arithmetic:
  - SLL fills with 0. SRL fills with 0.
  - SRA fills with the sign bit in_a[XLEN-1], captured at acceptance and carried down the pipe.
  - Shift by 0 returns in_a exactly.
  - No shift amount exceeds XLEN-1, because in_n is exactly log2(XLEN) bits.
- Latency and throughput:
  - An accepted op appears on out_valid exactly PIPE_STAGES cycles later if never stalled.
  - Throughput is one op per cycle.
- Flow control:
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when out_ready=1.
  - in_ready = !stage0_valid | stage0_advances. It is combinational from out_ready through the advance chain; there is no combinational path from in_valid.
- Stall:
  - While out_valid=1 and out_ready=0, out_result and out_tag hold stable.
  - Upstream stages fill; at most PIPE_STAGES ops are buffered, then in_ready=0.
  - No op is dropped or duplicated, and order is strictly preserved.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed; occupancy stays unchanged.
  - rst overrides all other activity.
- Reserved op 10 propagates in_a unchanged with normal latency and handshake.

Optional Feature:
SHIFT_WORD_OPS_EN
- With the macro:
  - Adds input in_word (1 bit), legal only when XLEN=64.
  - When in_word=1, the shift operates on in_a[31:0] with amount in_n[4:0]; in_n[5] is ignored.
  - SRA fills from in_a[31].
  - The 32-bit result is sign-extended from bit 31 to 64 bits (RV64 SLLW/SRLW/SRAW).
  - in_word is carried through the pipe like op. Latency is unchanged.
- Without the macro: the port is absent and all operations are full-width.

Test Plan:
1. SLL, in_a=64'hCAAAAAAAAAAAAAAA, in_n=1, out_ready=1 -> after 2 cycles out_valid=1, out_result=64'h9555555555555554, tag echoed.
2. SLL in_a=64'hF, n=4; SRL in_a=64'h8000000000000000, n=63; SRA same a, n=63, issued back-to-back -> results 64'hF0, 64'h1, 64'hFFFFFFFFFFFFFFFF on three consecutive cycles; in_ready stays high.
3. Backpressure: hold out_ready=0 and offer 4 ops with tags 1..4 -> in_ready drops after 2 accepts; out_result stable. Release -> tags emerge 1,2,3,4 in order, no loss.
4. Reset mid-flight: 2 ops accepted, assert rst for 1 cycle -> out_valid=0, busy=0 immediately; neither op is ever emitted.
5. Boundaries: n=0 for each op returns in_a; op=10 returns in_a; SRA of a positive value 64'h7FFFFFFFFFFFFFFF by 63 -> 0.
6. SHIFT_WORD_OPS_EN, in_word=1:
   - SLL a=1, n=31 -> 64'hFFFFFFFF80000000.
   - SRA a=64'h0000000080000000, n=4 -> 64'hFFFFFFFFF8000000.
   - SRL a=64'hFFFFFFFF00000010, n=36 (uses n[4:0]=4) -> 64'h1.
